// File: rtl/pwm_pkg.sv
// Shared PWM definitions: capture FSM states and the default frame geometry
// used by both the PWM generator and pwm_capture.
package pwm_pkg;

    localparam int CNT_W_DEF   = 4;
    localparam int TIMEOUT_DEF = 32;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW,
        STUCK
    } state_e;

endpackage

// File: rtl/pwm_in_sync.sv
// Input conditioning for pwm_capture: 2-flop synchronizer, optional glitch filter
// (PWM_CAPTURE_FILTER_EN) and registered rise/fall detect on the conditioned level.
module pwm_in_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic pwm_in,
    output logic s,
    output logic rise,
    output logic fall
);

    logic sync1_q, sync2_q;
    logic lvl;
    logic lvl_dly_q;
    logic rise_q, fall_q;

`ifdef PWM_CAPTURE_FILTER_EN
    logic sync3_q, filt_q;

    // Accept a new level only once two consecutive synchronized samples agree.
    assign lvl = (sync2_q == sync3_q) ? sync2_q : filt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync3_q <= 1'b0;
            filt_q  <= 1'b0;
        end else begin
            sync3_q <= sync2_q;
            filt_q  <= lvl;
        end
    end
`else
    assign lvl = sync2_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            lvl_dly_q <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
        end else begin
            sync1_q   <= pwm_in;
            sync2_q   <= sync1_q;
            lvl_dly_q <= lvl;
            rise_q    <= lvl & ~lvl_dly_q;
            fall_q    <= ~lvl & lvl_dly_q;
        end
    end

    // lvl_dly_q is the level that rise/fall refer to, so s stays aligned with them.
    assign s    = lvl_dly_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM receiver: measures high time and period per frame and reports the duty code.
// Define PWM_CAPTURE_FILTER_EN to add a 2-cycle glitch filter on the input.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] duty_out,
    output logic [CNT_W:0]   period_out,
    output logic             valid,
    output logic             stuck_hi,
    output logic             stuck_lo
);

    localparam int HC_W = CNT_W + 1;
    localparam int TC_W = $clog2(TIMEOUT) + 1;
    localparam logic [HC_W-1:0] HC_MAX   = '1;
    localparam logic [TC_W-1:0] TC_MAX   = '1;
    localparam logic [HC_W-1:0] DUTY_MAX = HC_W'((1 << CNT_W) - 1);
    localparam logic [HC_W:0]   PER_MAX  = (HC_W + 1)'((1 << (CNT_W + 1)) - 1);

    logic s, rise, fall;

    pwm_in_sync u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .pwm_in (pwm_in),
        .s      (s),
        .rise   (rise),
        .fall   (fall)
    );

    state_e            state_q, state_d;
    logic [HC_W-1:0]   hcnt_q, hcnt_d, lcnt_q, lcnt_d;
    logic [TC_W-1:0]   tcnt_q, tcnt_d;
    logic [CNT_W-1:0]  duty_q, duty_d;
    logic [CNT_W:0]    period_q, period_d;
    logic              valid_q, valid_d, shi_q, shi_d, slo_q, slo_d;

    logic [HC_W-1:0]   hcnt_inc, lcnt_inc, hm1;
    logic [TC_W-1:0]   tcnt_inc;
    logic [HC_W:0]     sum;
    logic [CNT_W-1:0]  duty_pub;
    logic [CNT_W:0]    period_pub;
    logic              timeout, do_start, do_pub, do_stuck;

    assign hcnt_inc   = (hcnt_q == HC_MAX) ? hcnt_q : hcnt_q + 1'b1;
    assign lcnt_inc   = (lcnt_q == HC_MAX) ? lcnt_q : lcnt_q + 1'b1;
    assign tcnt_inc   = (tcnt_q == TC_MAX) ? tcnt_q : tcnt_q + 1'b1;
    assign timeout    = (tcnt_q >= TC_W'(TIMEOUT));
    assign hm1        = hcnt_q - 1'b1;
    assign sum        = {1'b0, hcnt_q} + {1'b0, lcnt_q};
    assign duty_pub   = (hm1 > DUTY_MAX) ? '1 : hm1[CNT_W-1:0];
    assign period_pub = (sum > PER_MAX) ? '1 : sum[CNT_W:0];

    always_comb begin
        state_d  = state_q;
        hcnt_d   = hcnt_q;
        lcnt_d   = lcnt_q;
        tcnt_d   = tcnt_q;
        duty_d   = duty_q;
        period_d = period_q;
        shi_d    = shi_q;
        slo_d    = slo_q;
        valid_d  = 1'b0;
        do_start = 1'b0;
        do_pub   = 1'b0;
        do_stuck = 1'b0;

        // A rise is checked before the timeout so it wins when both coincide.
        unique case (state_q)
            IDLE: begin
                if (rise)         do_start = 1'b1;
                else if (timeout) do_stuck = 1'b1;
                else              tcnt_d   = tcnt_inc;
            end
            HIGH: begin
                if (timeout) begin
                    do_stuck = 1'b1;
                end else if (fall) begin
                    state_d = LOW;
                    lcnt_d  = HC_W'(1);
                    tcnt_d  = tcnt_inc;
                end else begin
                    hcnt_d = hcnt_inc;
                    tcnt_d = tcnt_inc;
                end
            end
            LOW: begin
                if (rise) begin
                    do_pub   = 1'b1;
                    do_start = 1'b1;
                end else if (timeout) begin
                    do_stuck = 1'b1;
                end else begin
                    lcnt_d = lcnt_inc;
                    tcnt_d = tcnt_inc;
                end
            end
            STUCK: begin
                if (rise) do_start = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (do_start) begin
            state_d = HIGH;
            hcnt_d  = HC_W'(1);
            tcnt_d  = TC_W'(1);
        end
        if (do_pub) begin
            duty_d   = duty_pub;
            period_d = period_pub;
            shi_d    = 1'b0;
            slo_d    = 1'b0;
            valid_d  = 1'b1;
        end
        if (do_stuck) begin
            state_d  = STUCK;
            duty_d   = s ? '1 : '0;
            period_d = '0;
            shi_d    = s;
            slo_d    = ~s;
            valid_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            hcnt_q   <= '0;
            lcnt_q   <= '0;
            tcnt_q   <= '0;
            duty_q   <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            shi_q    <= 1'b0;
            slo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            hcnt_q   <= hcnt_d;
            lcnt_q   <= lcnt_d;
            tcnt_q   <= tcnt_d;
            duty_q   <= duty_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            shi_q    <= shi_d;
            slo_q    <= slo_d;
        end
    end

    assign duty_out   = duty_q;
    assign period_out = period_q;
    assign valid      = valid_q;
    assign stuck_hi   = shi_q;
    assign stuck_lo   = slo_q;

endmodule
